// File: rtl/grid_stencil_addr_gen.sv
// -----------------------------------------------------------------------------
// grid_stencil_addr_gen
//
// Walks every cell of an HPIXELS x VPIXELS grid in row-major order after a
// start pulse. For each cell it presents the center BRAM address and the
// addresses of its left/right/up/down neighbours on a valid/ready stream.
// These addresses feed the stencil stages of the fluid solver.
//
// Addresses are built incrementally from a registered row base. There is no
// multiplier in the datapath. Every output comes straight from a register.
//
// Parameters:
//   HPIXELS  grid width in cells (>= 2)
//   VPIXELS  grid height in cells (>= 2)
//   WRAP     0 = clamp a missing neighbour to the cell itself,
//            1 = toroidal wrap
//
// Ports:
//   clk_in       system clock
//   rst_in       synchronous active-high reset (aborts a scan, no done pulse)
//   start_in     start a full-grid scan (honoured only while idle)
//   bank_sel_in  ping-pong bank select, sampled when start is accepted
//                (present only with GRID_ADDR_DOUBLE_BUFFER_EN)
//   busy_out     high while the scan is running
//   valid_out    current beat holds a cell
//   ready_in     downstream accepts the beat
//   hor_out      cell x
//   vert_out     cell y
//   addr_*_out   center / left / right / up / down addresses
//   last_out     beat is the final cell of the grid
//   done_out     one-cycle pulse after the final beat is accepted
//
// Optional feature macro: GRID_ADDR_DOUBLE_BUFFER_EN
//   When defined, the address outputs gain one bit. When bank 1 is selected,
//   HPIXELS*VPIXELS is added to every address.
// -----------------------------------------------------------------------------
module grid_stencil_addr_gen #(
    parameter int HPIXELS = 205,
    parameter int VPIXELS = 154,
    parameter int WRAP    = 0,
    localparam int HOR_SIZE  = $clog2(HPIXELS),
    localparam int VERT_SIZE = $clog2(VPIXELS),
    localparam int BRAM_SIZE = $clog2(HPIXELS*VPIXELS),
`ifdef GRID_ADDR_DOUBLE_BUFFER_EN
    localparam int ADDR_W    = BRAM_SIZE + 1
`else
    localparam int ADDR_W    = BRAM_SIZE
`endif
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
`ifdef GRID_ADDR_DOUBLE_BUFFER_EN
    input  logic                 bank_sel_in,
`endif
    output logic                 busy_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [HOR_SIZE-1:0]  hor_out,
    output logic [VERT_SIZE-1:0] vert_out,
    output logic [ADDR_W-1:0]    addr_c_out,
    output logic [ADDR_W-1:0]    addr_l_out,
    output logic [ADDR_W-1:0]    addr_r_out,
    output logic [ADDR_W-1:0]    addr_u_out,
    output logic [ADDR_W-1:0]    addr_d_out,
    output logic                 last_out,
    output logic                 done_out
);

    localparam logic [HOR_SIZE-1:0]  X_MAX    = HOR_SIZE'(HPIXELS - 1);
    localparam logic [VERT_SIZE-1:0] Y_MAX    = VERT_SIZE'(VPIXELS - 1);
    localparam logic [ADDR_W-1:0]    ROW_STEP = ADDR_W'(HPIXELS);
    localparam logic [ADDR_W-1:0]    LAST_ROW = ADDR_W'((VPIXELS - 1) * HPIXELS);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [HOR_SIZE-1:0]    x_reg, x_next;
    logic [VERT_SIZE-1:0]   y_reg, y_next;
    logic [ADDR_W-1:0]      base_reg, base_next;
    logic                   valid_reg, busy_reg, last_reg, done_reg;
    logic                   last_next;
    logic                   load, advance, step, finish;
    logic [ADDR_W-1:0]      center_next, bank_ofs_next;
    // Index order: 0 = center, 1 = left, 2 = right, 3 = up, 4 = down
    logic [ADDR_W-1:0]      addr_next [5];
    logic [ADDR_W-1:0]      addr_reg  [5];

    assign load    = (state_reg == IDLE) && start_in;
    assign advance = (state_reg == SCAN) && valid_reg && ready_in;
    assign step    = load || (advance && !last_reg);
    assign finish  = advance && last_reg;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_in) state_next = SCAN;
            SCAN:    if (finish)   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- next cell ----------------
    // On load the walk starts at (0,0). Otherwise it steps one cell, moving
    // to the next row and adding one row to the base at the right edge.
    always_comb begin
        x_next    = '0;
        y_next    = '0;
        base_next = '0;
        if (!load) begin
            if (x_reg == X_MAX) begin
                y_next    = y_reg + VERT_SIZE'(1);
                base_next = base_reg + ROW_STEP;
            end else begin
                x_next    = x_reg + HOR_SIZE'(1);
                y_next    = y_reg;
                base_next = base_reg;
            end
        end
        last_next = (x_next == X_MAX) && (y_next == Y_MAX);
    end

`ifdef GRID_ADDR_DOUBLE_BUFFER_EN
    localparam logic [ADDR_W-1:0] GRID_CELLS = ADDR_W'(HPIXELS * VPIXELS);
    logic bank_reg;

    // The bank is latched when start is accepted, so later toggles are ignored.
    always_ff @(posedge clk_in) begin
        if (rst_in)    bank_reg <= 1'b0;
        else if (load) bank_reg <= bank_sel_in;
    end

    assign bank_ofs_next = (load ? bank_sel_in : bank_reg) ? GRID_CELLS : '0;
`else
    assign bank_ofs_next = '0;
`endif

    // ---------------- neighbour addresses ----------------
    always_comb begin
        center_next = base_next + ADDR_W'(x_next);
        addr_next[0] = center_next;
        if (x_next == '0)
            addr_next[1] = (WRAP != 0) ? base_next + ROW_STEP - ADDR_W'(1) : center_next;
        else
            addr_next[1] = center_next - ADDR_W'(1);
        if (x_next == X_MAX)
            addr_next[2] = (WRAP != 0) ? base_next : center_next;
        else
            addr_next[2] = center_next + ADDR_W'(1);
        if (y_next == '0)
            addr_next[3] = (WRAP != 0) ? LAST_ROW + ADDR_W'(x_next) : center_next;
        else
            addr_next[3] = center_next - ROW_STEP;
        if (y_next == Y_MAX)
            addr_next[4] = (WRAP != 0) ? ADDR_W'(x_next) : center_next;
        else
            addr_next[4] = center_next + ROW_STEP;
    end

    // The address registers only load on a step. With ready_in low the
    // presented beat therefore holds stable.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_addr
            always_ff @(posedge clk_in) begin
                if (rst_in)    addr_reg[gi] <= '0;
                else if (step) addr_reg[gi] <= addr_next[gi] + bank_ofs_next;
            end
        end
    endgenerate

    // ---------------- control / coordinate registers ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_reg     <= '0;
            y_reg     <= '0;
            base_reg  <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= finish;
            if (step) begin
                x_reg     <= x_next;
                y_reg     <= y_next;
                base_reg  <= base_next;
                valid_reg <= 1'b1;
                busy_reg  <= 1'b1;
                last_reg  <= last_next;
            end else if (finish) begin
                valid_reg <= 1'b0;
                busy_reg  <= 1'b0;
                last_reg  <= 1'b0;
            end
        end
    end

    assign busy_out   = busy_reg;
    assign valid_out  = valid_reg;
    assign hor_out    = x_reg;
    assign vert_out   = y_reg;
    assign addr_c_out = addr_reg[0];
    assign addr_l_out = addr_reg[1];
    assign addr_r_out = addr_reg[2];
    assign addr_u_out = addr_reg[3];
    assign addr_d_out = addr_reg[4];
    assign last_out   = last_reg;
    assign done_out   = done_reg;

endmodule
